// File: rtl/ysyx_22051086_pkg.sv
// Shared definitions for the ysyx_22051086 write-back slice.
package ysyx_22051086_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/ysyx_22051086_rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is EXU, bit 1 is LSU.
module ysyx_22051086_rr_arb2
  import ysyx_22051086_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC_EXU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Any grant is a transfer because ready is the grant itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_EXU;
    end else if (|gnt) begin
      last_grant <= gnt[1] ? SRC_LSU : SRC_EXU;
    end
  end

endmodule

// File: rtl/ysyx_22051086_wbu.sv
// Write-back unit: arbitrates EXU/LSU results into one register-file write per cycle and
// keeps the pending-write scoreboard. Define YSYX_22051086_WB_BYPASS_EN for read forwarding.
module ysyx_22051086_wbu #(
  parameter int unsigned XLEN = ysyx_22051086_pkg::XLEN,
  parameter int unsigned NREG = ysyx_22051086_pkg::NREG
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 exu_valid,
  output logic                                 exu_ready,
  input  logic [ysyx_22051086_pkg::REG_AW-1:0] exu_rd,
  input  logic                                 exu_wen,
  input  logic [XLEN-1:0]                      exu_data,
  input  logic                                 lsu_valid,
  output logic                                 lsu_ready,
  input  logic [ysyx_22051086_pkg::REG_AW-1:0] lsu_rd,
  input  logic                                 lsu_wen,
  input  logic [XLEN-1:0]                      lsu_data,
  input  logic                                 iss_valid,
  input  logic [ysyx_22051086_pkg::REG_AW-1:0] iss_rd,
  input  logic                                 flush,
  input  logic [ysyx_22051086_pkg::REG_AW-1:0] raddr1,
  input  logic [ysyx_22051086_pkg::REG_AW-1:0] raddr2,
  output logic                                 busy1,
  output logic                                 busy2,
  output logic                                 rf_wen,
  output logic [ysyx_22051086_pkg::REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]                      rf_wdata,
  output logic [63:0]                          commit_cnt
`ifdef YSYX_22051086_WB_BYPASS_EN
  ,
  output logic                                 byp_hit1,
  output logic                                 byp_hit2,
  output logic [XLEN-1:0]                      byp_data1,
  output logic [XLEN-1:0]                      byp_data2
`endif
);

  localparam int unsigned AW = ysyx_22051086_pkg::REG_AW;

  logic [1:0]      gnt;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic            sel_wen;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_q, busy_d;

  ysyx_22051086_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_valid, exu_valid}),
    .gnt   (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign xfer      = |gnt;

  always_comb begin
    sel_rd   = gnt[1] ? lsu_rd   : exu_rd;
    sel_wen  = gnt[1] ? lsu_wen  : exu_wen;
    sel_data = gnt[1] ? lsu_data : exu_data;
  end

  // Address and data hold when idle; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (xfer) begin
      rf_wen   <= sel_wen && (sel_rd != '0);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
    end else if (xfer) begin
      commit_cnt <= commit_cnt + 64'd1;
    end
  end

  // Ordered so that an issue to the same rd overrides the write-back clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (rf_wen) begin
      busy_d[rf_waddr] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef YSYX_22051086_WB_BYPASS_EN
  always_comb begin
    byp_hit1  = rf_wen && (rf_waddr == raddr1) && (raddr1 != '0);
    byp_hit2  = rf_wen && (rf_waddr == raddr2) && (raddr2 != '0);
    byp_data1 = rf_wdata;
    byp_data2 = rf_wdata;
    busy1     = busy_q[raddr1] && !byp_hit1;
    busy2     = busy_q[raddr2] && !byp_hit2;
  end
`else
  assign busy1 = busy_q[raddr1];
  assign busy2 = busy_q[raddr2];
`endif

endmodule
